// File: rtl/duty_meas_pkg.sv
// Shared helpers for the multi-channel duty monitor: scaling shift,
// saturation value and the expected-value window compare.
package duty_meas_pkg;

    function automatic int duty_shift(input int win_bits, input int duty_w);
        return win_bits - duty_w;
    endfunction

    function automatic int duty_max_val(input int duty_w);
        return (1 << duty_w) - 1;
    endfunction

    // |duty - expected| <= margin; equality counts as in range.
    function automatic logic in_window(input int unsigned duty_v,
                                       input int unsigned exp_v,
                                       input int unsigned margin_v);
        int diff;
        diff = int'(duty_v) - int'(exp_v);
        if (diff < 0) diff = -diff;
        return (int'(margin_v) >= diff);
    endfunction

endpackage

// File: rtl/duty_meas_ch.sv
// One duty-measurement channel: input synchroniser, high-time counter,
// edge tracking, and the per-window result and statistics registers.
module duty_meas_ch
    import duty_meas_pkg::*;
#(
    parameter int WIN_BITS    = 11,
    parameter int DUTY_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm,
    input  logic              win_last,
    input  logic              clr_stats,
    input  logic [DUTY_W-1:0] exp_duty,
    input  logic [DUTY_W-1:0] margin,
    output logic [DUTY_W-1:0] duty,
    output logic [DUTY_W-1:0] duty_min,
    output logic [DUTY_W-1:0] duty_max,
    output logic              in_range,
    output logic              stuck
);

    localparam int SHIFT    = duty_shift(WIN_BITS, DUTY_W);
    localparam int DUTY_MAX = duty_max_val(DUTY_W);

    logic [SYNC_STAGES-1:0] sync;
    logic                   ps;
    logic                   ps_d;
    logic [WIN_BITS:0]      hi_cnt;
    logic [WIN_BITS:0]      total;
    logic [WIN_BITS:0]      scaled;
    logic [DUTY_W-1:0]      duty_next;
    logic                   edge_seen;
    logic                   edge_now;
    logic                   upd;

    assign ps       = sync[SYNC_STAGES-1];
    assign edge_now = ps ^ ps_d;

    // The final window sample is folded in here so the boundary cycle is counted once.
    assign total  = hi_cnt + {{WIN_BITS{1'b0}}, ps};
    assign scaled = total >> SHIFT;

    always_comb begin
        duty_next = scaled[DUTY_W-1:0];
        if (scaled > (WIN_BITS+1)'(DUTY_MAX)) duty_next = '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '0;
            ps_d      <= 1'b0;
            hi_cnt    <= '0;
            edge_seen <= 1'b0;
            duty      <= '0;
            in_range  <= 1'b0;
            stuck     <= 1'b0;
            upd       <= 1'b0;
        end else begin
            sync <= (sync << 1) | SYNC_STAGES'(pwm);
            ps_d <= ps;
            upd  <= win_last;
            if (win_last) begin
                hi_cnt    <= '0;
                edge_seen <= 1'b0;
                duty      <= duty_next;
                stuck     <= ~(edge_seen | edge_now);
                in_range  <= in_window(32'(duty_next), 32'(exp_duty), 32'(margin));
            end else begin
                hi_cnt    <= total;
                edge_seen <= edge_seen | edge_now;
            end
        end
    end

    // Stats fold in the duty shown during the update cycle; a coincident clear wins.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            duty_min <= '1;
            duty_max <= '0;
        end else if (upd) begin
            if (duty < duty_min) duty_min <= duty;
            if (duty > duty_max) duty_max <= duty;
        end
    end

endmodule

// File: rtl/duty_meas_multi.sv
// Multi-channel PWM duty monitor: shared window counter plus one
// measurement channel per PWM input, all updating on the same cycle.
module duty_meas_multi
    import duty_meas_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WIN_BITS    = 11,
    parameter int DUTY_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        pwm,
    input  logic                     clr_stats,
    input  logic [NUM_CH*DUTY_W-1:0] exp_duty,
    input  logic [DUTY_W-1:0]        margin,
    output logic [NUM_CH*DUTY_W-1:0] duty,
    output logic                     duty_vld,
    output logic [NUM_CH*DUTY_W-1:0] duty_min,
    output logic [NUM_CH*DUTY_W-1:0] duty_max,
    output logic [NUM_CH-1:0]        in_range,
    output logic [NUM_CH-1:0]        stuck
);

    logic [WIN_BITS-1:0] win_cnt;
    logic                win_last;

    assign win_last = &win_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt  <= '0;
            duty_vld <= 1'b0;
        end else begin
            win_cnt  <= win_cnt + 1'b1;
            duty_vld <= win_last;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        duty_meas_ch #(
            .WIN_BITS    (WIN_BITS),
            .DUTY_W      (DUTY_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .pwm       (pwm[i]),
            .win_last  (win_last),
            .clr_stats (clr_stats),
            .exp_duty  (exp_duty[i*DUTY_W +: DUTY_W]),
            .margin    (margin),
            .duty      (duty[i*DUTY_W +: DUTY_W]),
            .duty_min  (duty_min[i*DUTY_W +: DUTY_W]),
            .duty_max  (duty_max[i*DUTY_W +: DUTY_W]),
            .in_range  (in_range[i]),
            .stuck     (stuck[i])
        );
    end

endmodule

// File: tb/tb_duty_meas_multi.sv
// Bench for duty_meas_multi: directed PWM scenarios plus randomized
// periods, checked against a window-sampling reference model.
module tb_duty_meas_multi;

    localparam int NUM_CH      = 4;
    localparam int WIN_BITS    = 11;
    localparam int DUTY_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int WIN         = 1 << WIN_BITS;
    localparam int SHIFT       = WIN_BITS - DUTY_W;
    localparam int DMAX        = (1 << DUTY_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_CH-1:0]        pwm = '0;
    logic                     clr_stats = 1'b0;
    logic [NUM_CH*DUTY_W-1:0] exp_duty = '0;
    logic [DUTY_W-1:0]        margin = '0;
    logic [NUM_CH*DUTY_W-1:0] duty;
    logic                     duty_vld;
    logic [NUM_CH*DUTY_W-1:0] duty_min;
    logic [NUM_CH*DUTY_W-1:0] duty_max;
    logic [NUM_CH-1:0]        in_range;
    logic [NUM_CH-1:0]        stuck;

    duty_meas_multi #(
        .NUM_CH(NUM_CH), .WIN_BITS(WIN_BITS), .DUTY_W(DUTY_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .pwm(pwm), .clr_stats(clr_stats),
        .exp_duty(exp_duty), .margin(margin), .duty(duty), .duty_vld(duty_vld),
        .duty_min(duty_min), .duty_max(duty_max), .in_range(in_range), .stuck(stuck)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    logic [NUM_CH-1:0] hist[$];   // pwm value sampled at each edge since reset release
    int   ecount;
    int   tglob = 0;
    int   per_p[NUM_CH];
    int   per_h[NUM_CH];
    int   phase[NUM_CH];
    int   mdl_duty[NUM_CH];
    int   mdl_min[NUM_CH];
    int   mdl_max[NUM_CH];
    int   last_vld_e;
    logic vld_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [NUM_CH-1:0] gen(input int t);
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = (((t + phase[c]) % per_p[c]) < per_h[c]);
        return v;
    endfunction

    function automatic int samp(input int c, input int idx);
        logic [NUM_CH-1:0] v;
        if (idx < 0) return 0;
        v = hist[idx];
        return int'(v[c]);
    endfunction

    function automatic logic [DUTY_W-1:0] fld(input logic [NUM_CH*DUTY_W-1:0] bus, input int c);
        return bus[c*DUTY_W +: DUTY_W];
    endfunction

    // Model: the window closing at edge E counts the pwm samples the
    // synchroniser delivers across the 2^WIN_BITS edges ending at E.
    task automatic check_window();
        int e_last, total, ed, s, d, ex, diff;
        e_last = ecount - 1;
        for (int c = 0; c < NUM_CH; c++) begin
            total = 0;
            ed = 0;
            for (int e = e_last - WIN + 1; e <= e_last; e++) begin
                s = samp(c, e - SYNC_STAGES);
                total += s;
                if (s != samp(c, e - SYNC_STAGES - 1)) ed = 1;
            end
            d = total >> SHIFT;
            if (d > DMAX) d = DMAX;
            mdl_duty[c] = d;
            ex = int'(fld(exp_duty, c));
            diff = (d > ex) ? d - ex : ex - d;
            chk($sformatf("duty ch%0d e%0d", c, e_last), fld(duty, c), d);
            chk($sformatf("in_range ch%0d e%0d", c, e_last), in_range[c], (diff <= int'(margin)));
            chk($sformatf("stuck ch%0d e%0d", c, e_last), stuck[c], (ed == 0));
        end
        if (last_vld_e >= 0) chk("vld_spacing", e_last - last_vld_e, WIN);
        last_vld_e = e_last;
    endtask

    task automatic step();
        logic clr_now;
        clr_now = clr_stats;
        @(posedge clk);
        hist.push_back(pwm);
        ecount++;
        #1;
        if (clr_now || vld_q) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr_now) begin
                    mdl_min[c] = DMAX;
                    mdl_max[c] = 0;
                end else begin
                    if (mdl_duty[c] < mdl_min[c]) mdl_min[c] = mdl_duty[c];
                    if (mdl_duty[c] > mdl_max[c]) mdl_max[c] = mdl_duty[c];
                end
                chk($sformatf("min ch%0d", c), fld(duty_min, c), mdl_min[c]);
                chk($sformatf("max ch%0d", c), fld(duty_max, c), mdl_max[c]);
            end
        end
        vld_q = duty_vld;
        if (duty_vld) check_window();
        tglob++;
        pwm = gen(tglob);
    endtask

    task automatic run_windows(input int n);
        int seen, budget;
        seen = 0;
        budget = n * WIN + 64;
        while (seen < n && budget > 0) begin
            step();
            if (vld_q) seen++;
            budget--;
        end
        if (seen < n) chk("vld_timeout", seen, n);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst duty", duty, 0);
        chk("rst vld", duty_vld, 0);
        chk("rst min", duty_min, {NUM_CH*DUTY_W{1'b1}});
        chk("rst max", duty_max, 0);
        chk("rst in_range", in_range, 0);
        chk("rst stuck", stuck, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hist.delete();
        ecount = 0;
        vld_q = 1'b0;
        last_vld_e = -1;
        for (int c = 0; c < NUM_CH; c++) begin
            mdl_min[c] = DMAX;
            mdl_max[c] = 0;
            mdl_duty[c] = 0;
        end
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
    endtask

    initial begin
        int n, budget;
        for (int c = 0; c < NUM_CH; c++) begin
            per_p[c] = WIN;
            phase[c] = $urandom_range(WIN - 1, 0);
        end
        per_h[0] = 512;
        per_h[1] = 1912;
        per_h[2] = WIN;
        per_h[3] = 0;
        exp_duty = {8'h00, 8'hFF, 8'hEF, 8'h40};
        margin = 8'd6;
        pwm = gen(0);
        do_reset();

        // 25% on ch0, 1912/2048 on ch1, ch2 tied high, ch3 tied low
        run_windows(3);
        chk("ch0 25pct", fld(duty, 0), 8'h40);
        chk("ch0 not stuck", stuck[0], 1'b0);
        chk("ch1 0xEF", fld(duty, 1), 8'hEF);
        chk("ch1 in_range", in_range[1], 1'b1);
        chk("ch2 saturated", fld(duty, 2), 8'hFF);
        chk("ch2 stuck", stuck[2], 1'b1);
        chk("ch3 zero", fld(duty, 3), 8'h00);
        chk("ch3 stuck", stuck[3], 1'b1);

        per_h[1] = 1864;
        run_windows(2);
        chk("ch1 0xE9", fld(duty, 1), 8'hE9);
        chk("ch1 edge of margin", in_range[1], 1'b1);
        per_h[1] = 1856;
        run_windows(2);
        chk("ch1 0xE8", fld(duty, 1), 8'hE8);
        chk("ch1 out of range", in_range[1], 1'b0);

        per_h[2] = WIN / 2;
        run_windows(2);
        chk("ch2 50pct", fld(duty, 2), 8'h80);
        chk("ch2 released", stuck[2], 1'b0);

        // min/max tracking on ch0
        step();
        pulse_clr();
        chk("clr min", fld(duty_min, 0), 8'hFF);
        chk("clr max", fld(duty_max, 0), 8'h00);
        run_windows(1);
        step();
        chk("post-clr min", fld(duty_min, 0), 8'h40);
        chk("post-clr max", fld(duty_max, 0), 8'h40);
        per_h[0] = 1536;
        run_windows(2);
        per_h[0] = 256;
        run_windows(2);
        step();
        chk("steps min", fld(duty_min, 0), 8'h20);
        chk("steps max", fld(duty_max, 0), 8'hC0);

        // clear on the duty_vld cycle beats the update
        run_windows(1);
        pulse_clr();
        chk("clr@vld min", fld(duty_min, 0), 8'hFF);
        chk("clr@vld max", fld(duty_max, 0), 8'h00);
        chk("clr@vld duty", fld(duty, 0), 8'h20);
        run_windows(1);
        step();
        chk("after clr@vld min", fld(duty_min, 0), 8'h20);

        // random periods, expectations and clear pulses
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                per_p[c] = $urandom_range(4096, 64);
                per_h[c] = $urandom_range(per_p[c], 0);
                phase[c] = $urandom_range(4095, 0);
                exp_duty[c*DUTY_W +: DUTY_W] = DUTY_W'($urandom_range(DMAX, 0));
            end
            margin = DUTY_W'($urandom_range(24, 0));
            n = $urandom_range(1500, 10);
            repeat (n) step();
            if ($urandom_range(1, 0) == 1) pulse_clr();
            run_windows(1);
        end

        // reset in mid-window, then a fully fresh first window
        repeat ($urandom_range(1500, 300)) step();
        do_reset();
        budget = WIN + 64;
        while (!vld_q && budget > 0) begin
            step();
            budget--;
        end
        chk("first vld edges", ecount, WIN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
